// File: rtl/spimemory_master.sv
// SPI master for the spimemory slave: sequences one byte read or write per request.
// The frame is 7 address bits, an R/W bit, then write data or turnaround periods and read data.
module spimemory_master #(
    parameter int CLKDIV    = 4,
    parameter int READ_WAIT = 4,
    parameter int CS_IDLE   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       sclk_pin,
    output logic       cs_pin,
    output logic       mosi_pin,
    input  logic       miso_pin
);

    localparam int CNT_MAX = (READ_WAIT > 8) ? ((READ_WAIT > CS_IDLE) ? READ_WAIT : CS_IDLE)
                                             : ((CS_IDLE > 8) ? CS_IDLE : 8);
    localparam int BIT_W = $clog2(CNT_MAX);
    localparam int DIV_W = $clog2(2 * CLKDIV);

    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLKDIV - 1);
    localparam logic [DIV_W-1:0] PER_LAST  = DIV_W'(2 * CLKDIV - 1);
    localparam logic [BIT_W-1:0] WAIT_LAST = BIT_W'((READ_WAIT > 0) ? READ_WAIT - 1 : 0);
    localparam logic [BIT_W-1:0] GAP_LAST  = BIT_W'(CS_IDLE - 1);
    localparam logic [BIT_W-1:0] ADDR_LAST = BIT_W'(6);
    localparam logic [BIT_W-1:0] BYTE_LAST = BIT_W'(7);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_RW, S_WDATA, S_WAIT, S_RDATA, S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             sclk_q, sclk_d;
    logic             cs_q, cs_d;
    logic             mosi_q, mosi_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_rdata_q, rsp_rdata_d;
    logic             ready_q, ready_d;
    logic [14:0]      tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic             rw_q, rw_d;

    logic half_end, per_end;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        sclk_d      = sclk_q;
        cs_d        = cs_q;
        mosi_d      = mosi_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rw_d        = rw_q;
        half_end    = (div_q == HALF_LAST);
        per_end     = (div_q == PER_LAST);

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_ADDR;
                    cs_d    = 1'b0;
                    mosi_d  = req_addr[6];
                    tx_d    = {req_addr[5:0], req_rw, req_wdata};
                    rw_d    = req_rw;
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            default: begin
                div_d = per_end ? '0 : div_q + DIV_W'(1);
                // sclk never toggles in GAP so cs high always sees sclk low
                if (half_end && state_q != S_GAP) begin
                    sclk_d = 1'b1;
                    if (state_q == S_RDATA) rx_d = {rx_q[6:0], miso_pin};
                end
                if (per_end) begin
                    sclk_d = 1'b0;
                    bit_d  = bit_q + BIT_W'(1);
                    case (state_q)
                        S_ADDR: begin
                            mosi_d = tx_q[14];
                            tx_d   = {tx_q[13:0], 1'b0};
                            if (bit_q == ADDR_LAST) begin
                                state_d = S_RW;
                                bit_d   = '0;
                            end
                        end
                        S_RW: begin
                            bit_d = '0;
                            if (rw_q) begin
                                mosi_d  = 1'b0;
                                state_d = (READ_WAIT == 0) ? S_RDATA : S_WAIT;
                            end else begin
                                mosi_d  = tx_q[14];
                                tx_d    = {tx_q[13:0], 1'b0};
                                state_d = S_WDATA;
                            end
                        end
                        S_WDATA: begin
                            if (bit_q == BYTE_LAST) begin
                                state_d     = S_GAP;
                                bit_d       = '0;
                                cs_d        = 1'b1;
                                mosi_d      = 1'b0;
                                rsp_valid_d = 1'b1;
                            end else begin
                                mosi_d = tx_q[14];
                                tx_d   = {tx_q[13:0], 1'b0};
                            end
                        end
                        S_WAIT: begin
                            if (bit_q == WAIT_LAST) begin
                                state_d = S_RDATA;
                                bit_d   = '0;
                            end
                        end
                        S_RDATA: begin
                            if (bit_q == BYTE_LAST) begin
                                state_d     = S_GAP;
                                bit_d       = '0;
                                cs_d        = 1'b1;
                                rsp_valid_d = 1'b1;
                                rsp_rdata_d = rx_q;
                            end
                        end
                        S_GAP: begin
                            if (bit_q == GAP_LAST) begin
                                state_d = S_IDLE;
                                bit_d   = '0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            sclk_q      <= 1'b0;
            cs_q        <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            sclk_q      <= sclk_d;
            cs_q        <= cs_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            ready_q     <= ready_d;
        end
    end

    // Shift registers and captured request carry no reset; they are loaded before use
    always_ff @(posedge clk) begin
        tx_q <= tx_d;
        rx_q <= rx_d;
        rw_q <= rw_d;
    end

    assign req_ready = ready_q;
    assign busy      = ~ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign sclk_pin  = sclk_q;
    assign cs_pin    = cs_q;
    assign mosi_pin  = mosi_q;

endmodule

// File: tb/tb_spimemory_master.sv
// Bench for spimemory_master: two instances (default and CLKDIV=2), each driving
// a behavioural model of the spimemory slave.
module tb_spimemory_master;

    localparam int RW = 4;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       reset;
    logic       a_valid, a_rw, a_ready, a_rspv, a_busy, a_sclk, a_cs, a_mosi, a_miso;
    logic [6:0] a_addr;
    logic [7:0] a_wdata, a_rdata;
    logic       b_valid, b_rw, b_ready, b_rspv, b_busy, b_sclk, b_cs, b_mosi, b_miso;
    logic [6:0] b_addr;
    logic [7:0] b_wdata, b_rdata;

    int checks = 0;
    int errors = 0;

    spimemory_master #(.CLKDIV(4), .READ_WAIT(RW), .CS_IDLE(1)) dut_a (
        .clk(clk), .reset(reset), .req_valid(a_valid), .req_ready(a_ready),
        .req_rw(a_rw), .req_addr(a_addr), .req_wdata(a_wdata),
        .rsp_valid(a_rspv), .rsp_rdata(a_rdata), .busy(a_busy),
        .sclk_pin(a_sclk), .cs_pin(a_cs), .mosi_pin(a_mosi), .miso_pin(a_miso));

    spimemory_master #(.CLKDIV(2), .READ_WAIT(RW), .CS_IDLE(1)) dut_b (
        .clk(clk), .reset(reset), .req_valid(b_valid), .req_ready(b_ready),
        .req_rw(b_rw), .req_addr(b_addr), .req_wdata(b_wdata),
        .rsp_valid(b_rspv), .rsp_rdata(b_rdata), .busy(b_busy),
        .sclk_pin(b_sclk), .cs_pin(b_cs), .mosi_pin(b_mosi), .miso_pin(b_miso));

    // Slave model A: shifts mosi on sclk rise, drives miso after sclk fall
    int          a_rise = 0;
    logic        a_rd = 1'b0;
    logic [6:0]  a_maddr;
    logic [15:0] a_sh, a_frame;
    logic [7:0]  mem_a [128];
    initial a_miso = 1'b0;
    always @(posedge a_sclk) if (a_cs === 1'b0) begin
        a_sh = {a_sh[14:0], a_mosi};
        a_rise++;
        if (a_rise == 8) begin a_maddr = a_sh[7:1]; a_rd = a_sh[0]; end
        if (a_rise == 16 && !a_rd) mem_a[a_sh[15:9]] = a_sh[7:0];
    end
    always @(negedge a_sclk)
        if (a_cs === 1'b0 && a_rd && a_rise >= 8 + RW && a_rise < 16 + RW)
            a_miso = mem_a[a_maddr][15 + RW - a_rise];
        else a_miso = 1'b0;
    always @(posedge a_cs) begin a_frame = a_sh; a_rise = 0; a_rd = 1'b0; a_miso = 1'b0; end

    // Slave model B
    int          b_rise = 0;
    logic        b_rd = 1'b0;
    logic [6:0]  b_maddr;
    logic [15:0] b_sh;
    logic [7:0]  mem_b [128];
    initial b_miso = 1'b0;
    always @(posedge b_sclk) if (b_cs === 1'b0) begin
        b_sh = {b_sh[14:0], b_mosi};
        b_rise++;
        if (b_rise == 8) begin b_maddr = b_sh[7:1]; b_rd = b_sh[0]; end
        if (b_rise == 16 && !b_rd) mem_b[b_sh[15:9]] = b_sh[7:0];
    end
    always @(negedge b_sclk)
        if (b_cs === 1'b0 && b_rd && b_rise >= 8 + RW && b_rise < 16 + RW)
            b_miso = mem_b[b_maddr][15 + RW - b_rise];
        else b_miso = 1'b0;
    always @(posedge b_cs) begin b_rise = 0; b_rd = 1'b0; b_miso = 1'b0; end

    // Pin monitor on instance A: cs low/high run lengths and waveform rule violations
    int   lo = 0, hi = 0, lo_len = 0, hi_len = 0, viol = 0, acc = 0;
    logic prev_mosi = 1'b0;
    always @(negedge clk) begin
        if (a_cs === 1'b1) begin
            if (a_sclk !== 1'b0) viol++;
            if (lo > 0) begin lo_len = lo; lo = 0; end
            hi++;
        end else begin
            if (hi > 0) begin hi_len = hi; hi = 0; end
            lo++;
            if (a_sclk === 1'b1 && a_mosi !== prev_mosi) viol++;
        end
        prev_mosi = a_mosi;
    end
    always @(posedge clk) if (a_valid && a_ready) acc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    function automatic logic rdy(input bit w); return w ? b_ready : a_ready; endfunction
    function automatic logic rspv(input bit w); return w ? b_rspv : a_rspv; endfunction

    // Runs one transaction starting at a negedge; lat = negedges from accept to rsp_valid
    task automatic txn(input bit w, input bit rw, input logic [6:0] addr, input logic [7:0] wd,
                       output logic [7:0] rd, output int lat);
        int k = 0;
        while (!rdy(w) && k < 400) begin @(negedge clk); k++; end
        if (k >= 400) timeout("ready_wait");
        if (w) begin b_valid = 1; b_rw = rw; b_addr = addr; b_wdata = wd; end
        else   begin a_valid = 1; a_rw = rw; a_addr = addr; a_wdata = wd; end
        @(negedge clk);
        a_valid = 0; b_valid = 0;
        if (w) check("start_pins_b", {29'd0, b_cs, b_sclk, b_mosi}, {29'd0, 2'b00, addr[6]});
        else   check("start_pins_a", {29'd0, a_cs, a_sclk, a_mosi}, {29'd0, 2'b00, addr[6]});
        lat = 1;
        while (!rspv(w) && lat < 400) begin @(negedge clk); lat++; end
        if (lat >= 400) timeout("rsp_wait");
        rd = w ? b_rdata : a_rdata;
        @(negedge clk);
        check("rsp_pulse", {31'd0, rspv(w)}, 32'd0);
    endtask

    logic [7:0] rd;
    int lat;

    initial begin
        reset = 1;
        a_valid = 0; a_rw = 0; a_addr = 0; a_wdata = 0;
        b_valid = 0; b_rw = 0; b_addr = 0; b_wdata = 0;
        repeat (3) @(negedge clk);
        reset = 0;
        check("reset_pins", {29'd0, a_cs, a_sclk, a_mosi}, 32'h4);
        check("reset_rsp", {23'd0, a_rspv, a_rdata}, 32'h0);
        check("reset_ready", {30'd0, a_ready, a_busy}, 32'h2);
        check("reset_ready_b", {30'd0, b_ready, b_busy}, 32'h2);
        @(negedge clk);

        // Write then read
        txn(0, 0, 7'h5A, 8'hDB, rd, lat);
        check("wr_latency", lat, 129);
        txn(0, 1, 7'h5A, 8'h00, rd, lat);
        check("rd_latency", lat, 161);
        check("rd_5A", rd, 8'hDB);

        // Persistence; a write leaves rsp_rdata unchanged
        txn(0, 0, 7'h16, 8'h55, rd, lat);
        check("wr_keeps_rdata", a_rdata, 8'hDB);
        txn(0, 1, 7'h5A, 8'h00, rd, lat);
        check("rd_5A_again", rd, 8'hDB);
        txn(0, 1, 7'h16, 8'h00, rd, lat);
        check("rd_16", rd, 8'h55);

        for (int i = 0; i < 128; i++) txn(0, 0, 7'(i), 8'(i), rd, lat);
        for (int i = 0; i < 128; i++) begin
            txn(0, 1, 7'(i), 8'h00, rd, lat);
            check($sformatf("sweep_%02h", i), rd, 8'(i));
        end

        // Pin waveform of a write of 0xA5 to 0x7F
        txn(0, 0, 7'h7F, 8'hA5, rd, lat);
        check("frame_bits", a_frame, 16'hFEA5);
        check("cs_low_cycles", lo_len, 128);

        // Request held while busy with fields changing mid-transfer
        acc = 0;
        a_valid = 1; a_rw = 0; a_addr = 7'h10; a_wdata = 8'h11;
        @(negedge clk);
        check("busy_after_accept", {31'd0, a_busy}, 32'd1);
        repeat (20) @(negedge clk);
        a_addr = 7'h20; a_wdata = 8'h22;
        begin
            int k = 0;
            while (!a_ready && k < 400) begin @(negedge clk); k++; end
            if (k >= 400) timeout("busy_ready_wait");
        end
        @(negedge clk);
        a_valid = 0;
        @(negedge clk);
        check("cs_high_min", {31'd0, hi_len >= 8}, 32'd1);
        begin
            int k = 0;
            while (!a_ready && k < 400) begin @(negedge clk); k++; end
            if (k >= 400) timeout("busy_done_wait");
        end
        check("accept_count", acc, 2);
        txn(0, 1, 7'h10, 8'h00, rd, lat);
        check("captured_10", rd, 8'h11);
        txn(0, 1, 7'h20, 8'h00, rd, lat);
        check("captured_20", rd, 8'h22);

        // Reset during RDATA
        txn(0, 0, 7'h5A, 8'hDB, rd, lat);
        a_valid = 1; a_rw = 1; a_addr = 7'h5A;
        @(negedge clk);
        a_valid = 0;
        repeat (109) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("rst_mid_pins", {30'd0, a_cs, a_sclk}, 32'h2);
        check("rst_mid_rdata", a_rdata, 8'h00);
        check("rst_mid_ready", {30'd0, a_ready, a_busy}, 32'h2);
        begin
            int seen = 0;
            repeat (200) begin @(negedge clk); if (a_rspv) seen++; end
            check("rst_no_rsp", seen, 0);
        end
        txn(0, 1, 7'h5A, 8'h00, rd, lat);
        check("rd_after_reset", rd, 8'hDB);

        // CLKDIV=2 instance
        txn(1, 0, 7'h44, 8'h33, rd, lat);
        check("b_wr_latency", lat, 65);
        txn(1, 1, 7'h44, 8'h00, rd, lat);
        check("b_rd_latency", lat, 81);
        check("b_rd_44", rd, 8'h33);
        txn(1, 0, 7'h7F, 8'hFF, rd, lat);
        txn(1, 1, 7'h7F, 8'h00, rd, lat);
        check("b_rd_7F", rd, 8'hFF);

        check("waveform_violations", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
